// File: rtl/safety_island_boot_ctrl.sv
`timescale 1ns/1ps
// safety_island_boot_ctrl
// AXI4-Lite subordinate that holds the safety island boot-control registers
// and drives the core-complex boot pins.
//   0x0 BOOTMODE[1:0]   RW
//   0x4 BOOT_ADDR[31:0] RW
//   0x8 FETCH_EN[0]     RW
//   0xC STATUS          RO  [31] sticky EOC (write 1 clears), [30:0] exit code
// Any address with bits above [3:2] set returns SLVERR, reads 0 and changes
// nothing.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   aw_*/w_*/b_*                  AXI-Lite write channels
//   ar_*/r_*                      AXI-Lite read channels
//   bootmode_o, boot_addr_o,
//   fetch_en_o                    boot pins to the core complex
//   eoc_i, exit_code_i            EOC pulse and exit code from the core
module safety_island_boot_ctrl #(
  parameter int          AddrWidth   = 12,
  parameter logic [31:0] DefBootAddr = 32'h1C00_0080,
  parameter logic [1:0]  DefBootMode = 2'd0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [31:0]          w_data_i,
  input  logic [3:0]           w_strb_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [31:0]          r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [1:0]           bootmode_o,
  output logic [31:0]          boot_addr_o,
  output logic                 fetch_en_o,
  input  logic                 eoc_i,
  input  logic [30:0]          exit_code_i
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_RESP} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  // Holds all readies low until the first clock after reset release.
  logic init_q;

  logic [AddrWidth-1:0] aw_addr_q;
  logic [31:0]          w_data_q;
  logic [3:0]           w_strb_q;
  logic [1:0]           b_resp_q;
  logic [31:0]          r_data_q;
  logic [1:0]           r_resp_q;

  logic [1:0]  bootmode_q;
  logic [31:0] boot_addr_q;
  logic        fetch_en_q;
  logic        eoc_q;
  logic [30:0] exit_code_q;

  logic                 aw_hs, w_hs, ar_hs;
  logic                 lat_aw, lat_w, wr_en, wr_ok;
  logic [AddrWidth-1:0] wr_addr;
  logic [31:0]          wr_data;
  logic [3:0]           wr_strb;
  logic [1:0]           wr_idx;
  logic                 rd_ok;
  logic [31:0]          rd_data;

  function automatic logic addr_legal(input logic [AddrWidth-1:0] a);
    return a[AddrWidth-1:4] == '0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = nw[8*i +: 8];
    return res;
  endfunction

  assign aw_ready_o = init_q & ((wstate_q == W_IDLE) | (wstate_q == W_WAIT_AW));
  assign w_ready_o  = init_q & ((wstate_q == W_IDLE) | (wstate_q == W_WAIT_W));
  assign b_valid_o  = (wstate_q == W_RESP);
  assign b_resp_o   = b_resp_q;
  assign ar_ready_o = init_q & (rstate_q == R_IDLE);
  assign r_valid_o  = (rstate_q == R_RESP);
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i & w_ready_o;
  assign ar_hs = ar_valid_i & ar_ready_o;

  // Write FSM: the commit beat takes whichever half is live this cycle and
  // the other half from its holding register.
  always_comb begin
    wstate_d = wstate_q;
    wr_en    = 1'b0;
    lat_aw   = 1'b0;
    lat_w    = 1'b0;
    wr_addr  = aw_addr_i;
    wr_data  = w_data_i;
    wr_strb  = w_strb_i;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_en    = 1'b1;
          wstate_d = W_RESP;
        end else if (aw_hs) begin
          lat_aw   = 1'b1;
          wstate_d = W_WAIT_W;
        end else if (w_hs) begin
          lat_w    = 1'b1;
          wstate_d = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        wr_addr = aw_addr_q;
        if (w_hs) begin
          wr_en    = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_WAIT_AW: begin
        wr_data = w_data_q;
        wr_strb = w_strb_q;
        if (aw_hs) begin
          wr_en    = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: if (b_ready_i) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  assign wr_ok  = wr_en & addr_legal(wr_addr);
  assign wr_idx = wr_addr[3:2];

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_RESP;
      R_RESP:  if (r_ready_i) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read mux sees register state before any same-edge write.
  assign rd_ok = addr_legal(ar_addr_i);
  always_comb begin
    rd_data = 32'h0;
    if (rd_ok) begin
      case (ar_addr_i[3:2])
        2'd0:    rd_data = {30'h0, bootmode_q};
        2'd1:    rd_data = boot_addr_q;
        2'd2:    rd_data = {31'h0, fetch_en_q};
        default: rd_data = {eoc_q, exit_code_q};
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q    <= 1'b0;
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= RespOkay;
      r_data_q  <= '0;
      r_resp_q  <= RespOkay;
    end else begin
      init_q   <= 1'b1;
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      if (lat_aw) aw_addr_q <= aw_addr_i;
      if (lat_w) begin
        w_data_q <= w_data_i;
        w_strb_q <= w_strb_i;
      end
      if (wr_en) b_resp_q <= addr_legal(wr_addr) ? RespOkay : RespSlvErr;
      if (ar_hs) begin
        r_data_q <= rd_data;
        r_resp_q <= rd_ok ? RespOkay : RespSlvErr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bootmode_q  <= DefBootMode;
      boot_addr_q <= DefBootAddr;
      fetch_en_q  <= 1'b0;
      eoc_q       <= 1'b0;
      exit_code_q <= '0;
    end else begin
      if (wr_ok && wr_idx == 2'd0 && wr_strb[0]) bootmode_q <= wr_data[1:0];
      if (wr_ok && wr_idx == 2'd1) boot_addr_q <= merge(boot_addr_q, wr_data, wr_strb);
      if (wr_ok && wr_idx == 2'd2 && wr_strb[0]) fetch_en_q <= wr_data[0];
      // A new EOC pulse beats a simultaneous W1C so no completion is lost.
      if (eoc_i) begin
        eoc_q       <= 1'b1;
        exit_code_q <= exit_code_i;
      end else if (wr_ok && wr_idx == 2'd3 && wr_strb[3] && wr_data[31]) begin
        eoc_q <= 1'b0;
      end
    end
  end

  assign bootmode_o  = bootmode_q;
  assign boot_addr_o = boot_addr_q;
  assign fetch_en_o  = fetch_en_q;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{wr_addr[1:0], ar_addr_i[1:0]};

endmodule
